// File: rtl/pm_fault_sequencer.sv
// Power-monitor fault sequencer: per-rail power-good filtering, start-up qualification,
// fault shutdown with timed retry and lockout. Optional warn edge counter: PM_SEQ_WARN_COUNT_EN.
module pm_fault_sequencer #(
    parameter int NumConverters = 8,
    parameter int FilterCount   = 3,
    parameter int QualifyCycles = 4096,
    parameter int HoldCycles    = 1000,
    parameter int MaxRetries    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        fault,
    input  logic        warn,
    input  logic        eoc,
    input  logic [31:0] pgood_bus,
    output logic [31:0] pgood_filt,
    output logic        all_good,
    output logic        shutdown,
    output logic        fault_latched,
    output logic        warn_seen,
    output logic        lockout,
    output logic [3:0]  retry_cnt,
    output logic [7:0]  warn_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_RUN,
        ST_FAULT,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0]  FiltLast = 4'(FilterCount - 1);
    localparam logic [15:0] QualLast = 16'(QualifyCycles - 1);
    localparam logic [15:0] HoldLast = 16'(HoldCycles - 1);
    localparam logic [3:0]  RetryMax = 4'(MaxRetries);

    logic [NumConverters-1:0] r_filt;
    logic [3:0]               r_cnt [NumConverters];
    logic                     r_all_good;
    logic                     w_unused_pgood;

    assign w_unused_pgood = ^pgood_bus;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_filt     <= '0;
            r_all_good <= 1'b0;
            // NOTE: the per-rail counters are plain flops, not RAM, so they take the reset like any other state.
            for (int i = 0; i < NumConverters; i++) r_cnt[i] <= '0;
        end else begin
            r_all_good <= &r_filt;
            if (eoc) begin
                for (int i = 0; i < NumConverters; i++) begin
                    if (pgood_bus[i] == r_filt[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == FiltLast) begin
                        r_filt[i] <= pgood_bus[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    state_t      r_state;
    logic [15:0] r_timer;
    logic [15:0] w_timer_inc;
    logic [3:0]  r_retry;
    logic        r_shutdown;
    logic        r_lockout;
    logic        r_fault_latched;
    logic        r_warn_seen;

    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_retry         <= '0;
            r_shutdown      <= 1'b1;
            r_lockout       <= 1'b0;
            r_fault_latched <= 1'b0;
            r_warn_seen     <= 1'b0;
        end else begin
            // NOTE: the last nonblocking assignment in a block wins, so any set further down overrides this clear.
            if (clear) begin
                r_fault_latched <= 1'b0;
                r_warn_seen     <= 1'b0;
            end
            if (warn) r_warn_seen <= 1'b1;

            if (r_state == ST_LOCKOUT) begin
                if (clear) begin
                    r_state   <= ST_IDLE;
                    r_timer   <= '0;
                    r_lockout <= 1'b0;
                end
            end else if (!enable) begin
                r_state    <= ST_IDLE;
                r_timer    <= '0;
                r_shutdown <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_QUALIFY;
                        r_timer    <= '0;
                        r_retry    <= '0;
                        r_shutdown <= 1'b0;
                    end
                    ST_QUALIFY: begin
                        if (fault || (!r_all_good && r_timer == QualLast)) begin
                            r_state         <= ST_FAULT;
                            r_timer         <= '0;
                            r_shutdown      <= 1'b1;
                            r_fault_latched <= 1'b1;
                        end else if (r_all_good) begin
                            r_state <= ST_RUN;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    ST_RUN: begin
                        if (fault || !r_all_good) begin
                            r_state         <= ST_FAULT;
                            r_timer         <= '0;
                            r_shutdown      <= 1'b1;
                            r_fault_latched <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (r_timer == HoldLast) begin
                            r_timer <= '0;
                            if (r_retry < RetryMax) begin
                                r_retry    <= r_retry + 4'd1;
                                r_state    <= ST_QUALIFY;
                                r_shutdown <= 1'b0;
                            end else begin
                                r_state   <= ST_LOCKOUT;
                                r_lockout <= 1'b1;
                            end
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_timer    <= '0;
                        r_shutdown <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef PM_SEQ_WARN_COUNT_EN
    logic       r_warn_d;
    logic [7:0] r_warn_count;
    logic       w_warn_edge;

    assign w_warn_edge = warn & ~r_warn_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_warn_d     <= 1'b0;
            r_warn_count <= '0;
        end else begin
            r_warn_d <= warn;
            if (clear) begin
                r_warn_count <= {7'd0, w_warn_edge};
            end else if (w_warn_edge && r_warn_count != 8'hFF) begin
                r_warn_count <= r_warn_count + 8'd1;
            end
        end
    end

    assign warn_count = r_warn_count;
`else
    assign warn_count = 8'h00;
`endif

    assign pgood_filt    = 32'(r_filt);
    assign all_good      = r_all_good;
    assign shutdown      = r_shutdown;
    assign fault_latched = r_fault_latched;
    assign warn_seen     = r_warn_seen;
    assign lockout       = r_lockout;
    assign retry_cnt     = r_retry;

endmodule
